router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet source for the router input port, and the other end of the router's input protocol. The block accepts a command (destination address plus payload length), buffers the payload bytes from the host, and then emits the framed packet onto the router input: a header byte, the payload bytes, and an XOR parity byte. It honours the router's `busy` back-pressure and inserts a mandatory idle gap between packets. It sits in front of the router in both the system and the testbench.

## Interface
- `GAP_CYCLES`, default 2: idle cycles (`pkt_valid`=0, `data_out`=0) after the parity byte is consumed.
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_addr` in 2: destination port 0..2; 3 is illegal.
- `cmd_len` in 6: payload length 1..63; 0 is illegal.
- `cmd_ready` out 1: high only in IDLE; decoded from the state register.
- `cmd_err` out 1: one-cycle pulse when an illegal command is rejected.
- `pl_valid` in 1: payload byte valid.
- `pl_data` in 8: payload byte.
- `pl_ready` out 1: high in LOAD.
- `busy` in 1: router stall; the current output byte is held while high.
- `pkt_valid` out 1: registered; high for the header and payload bytes, low for the parity byte.
- `data_out` out 8: registered router data.
- `done` out 1: one-cycle pulse on the edge that consumes the parity byte.

## Operation
- States: IDLE, LOAD, HDR, PAYLOAD, PARITY, GAP.
- **IDLE**
  - A command is accepted on an edge with `cmd_valid && cmd_ready`.
  - If `cmd_addr`==3 or `cmd_len`==0: pulse `cmd_err` the next cycle and stay in IDLE.
  - Otherwise: latch `header = {cmd_len, cmd_addr}`, set `parity = header`, clear the index, and go to LOAD.
- **LOAD**
  - On each edge with `pl_valid && pl_ready`: write `buf[idx] <= pl_data`, `parity ^= pl_data`, `idx++`.
  - The edge that writes byte `len-1` moves to HDR and, on the same edge, loads `data_out=header` and `pkt_valid=1`.
- **Byte advance rule:** the byte on the outputs in a cycle is consumed at the ending edge iff `busy==0` in that cycle. The outputs advance only on consuming edges; otherwise they hold exactly.
- **HDR → PAYLOAD:** drive `buf[0]` .. `buf[len-1]` with `pkt_valid=1`.
- **Last payload byte consumed:** go to PARITY, with `data_out=parity` and `pkt_valid=0`.
- **PARITY consumed:** pulse `done`, drive `data_out=0`, enter GAP.
- **GAP:** count `GAP_CYCLES` edges regardless of `busy`, then go to IDLE.
- Parity is the 8-bit XOR of the header and all payload bytes; no carries, no widening.
- Reset values:
  - state IDLE;
  - `pkt_valid`, `data_out`, `cmd_err`, `done`, `pl_ready` all 0;
  - `cmd_ready` 1 once in IDLE;
  - buffer contents are don't-care.
- Reset mid-packet aborts immediately; no partial parity is emitted.

## Timing
- From the last payload-accept edge, the header is on the pins in the following cycle.
- Minimum wire time per packet: len+2 cycles (header, payload, parity), plus `GAP_CYCLES`, plus 1 cycle in IDLE.
- `busy` asserted during HDR, PAYLOAD or PARITY stretches that byte by the number of busy cycles. `pkt_valid` never toggles during a stall.
- `cmd_err` and `done` are exactly one cycle wide.
- Commands presented outside IDLE are ignored (`cmd_ready`=0).

## Configuration
- `ROUTER_TX_PARITY_ERR_INJ_EN` defined:
  - adds input `corrupt_parity` (1 bit), sampled at command accept;
  - when it was 1, the emitted parity byte is `~parity`, which drives the router's error path.
- Undefined: the port is absent and parity is always correct.

## Structure
- Shared package `router_pkg` holds:
  - the state enum `tx_state_t`;
  - `ADDR_W`=2, `LEN_W`=6, `DATA_W`=8;
  - `ADDR_ILLEGAL`=2'b11;
  - the header packing function `{len, addr}`.
- One sub-module `router_tx_buf`:
  - 64x8 synchronous-write, asynchronous-read storage;
  - write on accepted payload beats, read indexed by the send pointer.

## Test plan
- Basic packet: addr=1, len=3, payload 0x11,0x22,0x33, `busy`=0.
  - Expect `data_out` 0x0D,0x11,0x22,0x33 with `pkt_valid`=1, then 0x0D with `pkt_valid`=0.
  - Expect a `done` pulse, then 2 gap cycles.
- Stall: same packet, `busy`=1 for 3 cycles while 0x22 is driven.
  - Expect 0x22 held for 4 cycles and `pkt_valid` steady at 1.
  - Remaining bytes and parity unchanged.
- Illegal commands: addr=3 len=5, and addr=0 len=0.
  - Expect a `cmd_err` pulse each time and `pl_ready` never asserted.
  - Expect no router traffic; state stays IDLE.
- Maximum length: addr=2, len=63, payload 0x00..0x3E.
  - Expect header 0xFE and 63 bytes in order.
  - Expect parity 0xFE ^ XOR(0x00..0x3E) = 0xC1.
- Back-to-back with reset:
  - Command 2 is held valid during packet 1; expect it accepted only after the gap.
  - Assert `reset` during PAYLOAD; expect `pkt_valid`=0 and `data_out`=0 on the next cycle, and state IDLE.
- With `ROUTER_TX_PARITY_ERR_INJ_EN` defined and `corrupt_parity`=1 on the basic packet: expect parity byte 0xF2.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet source.
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } tx_state_t;

    // Header byte layout: length in the upper six bits, destination in the lower two.
    function automatic logic [DATA_W-1:0] pack_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store: 64x8, synchronous write, asynchronous read.
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [LEN_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [LEN_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<LEN_W)-1];

    // Capture each accepted payload beat; contents need no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a payload, then emits
// header, payload and XOR parity under busy back-pressure, followed
// by an idle gap. Optional feature macro: ROUTER_TX_PARITY_ERR_INJ_EN
// (adds corrupt_parity to invert the emitted parity byte).
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    input  logic              corrupt_parity,
`endif
    output logic              cmd_ready,
    output logic              cmd_err,
    input  logic              pl_valid,
    input  logic [DATA_W-1:0] pl_data,
    output logic              pl_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              done
);

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_header;
    logic [DATA_W-1:0] r_parity;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [15:0]       r_gap_cnt;
    logic              r_pkt_valid;
    logic [DATA_W-1:0] r_data_out;
    logic              r_cmd_err;
    logic              r_done;

    logic              w_cmd_fire;
    logic              w_cmd_illegal;
    logic              w_pl_fire;
    logic              w_consume;
    logic              w_last_load;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_parity_out;

    assign cmd_ready     = (r_state == S_IDLE);
    assign pl_ready      = (r_state == S_LOAD);
    assign w_cmd_fire    = cmd_valid && cmd_ready;
    assign w_cmd_illegal = (cmd_addr == ADDR_ILLEGAL) || (cmd_len == '0);
    assign w_pl_fire     = pl_valid && pl_ready;
    assign w_consume     = !busy;
    assign w_last_load   = (r_idx == (r_len - 6'd1));

`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    logic r_corrupt;

    // Latch the corruption request together with the command.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_corrupt <= 1'b0;
        end else if (w_cmd_fire && !w_cmd_illegal) begin
            r_corrupt <= corrupt_parity;
        end
    end

    assign w_parity_out = r_corrupt ? ~r_parity : r_parity;
`else
    assign w_parity_out = r_parity;
`endif

    // Write and read share r_idx: it is the load index in LOAD and the
    // send pointer (next payload byte to drive) in HDR/PAYLOAD.
    router_tx_buf u_buf (
        .clk     (clk),
        .i_we    (w_pl_fire),
        .i_waddr (r_idx),
        .i_wdata (pl_data),
        .i_raddr (r_idx),
        .o_rdata (w_rd_data)
    );

    // Packet FSM with registered router-side outputs and pulse flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_header    <= '0;
            r_parity    <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_gap_cnt   <= '0;
            r_pkt_valid <= 1'b0;
            r_data_out  <= '0;
            r_cmd_err   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        if (w_cmd_illegal) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_header <= pack_header(cmd_len, cmd_addr);
                            r_parity <= pack_header(cmd_len, cmd_addr);
                            r_len    <= cmd_len;
                            r_idx    <= '0;
                            r_state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_pl_fire) begin
                        r_parity <= r_parity ^ pl_data;
                        if (w_last_load) begin
                            r_idx       <= '0;
                            r_data_out  <= r_header;
                            r_pkt_valid <= 1'b1;
                            r_state     <= S_HDR;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                S_HDR: begin
                    if (w_consume) begin
                        r_data_out <= w_rd_data;
                        r_idx      <= r_idx + 6'd1;
                        r_state    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    // r_idx == r_len means every payload byte has been driven.
                    if (w_consume) begin
                        if (r_idx == r_len) begin
                            r_data_out  <= w_parity_out;
                            r_pkt_valid <= 1'b0;
                            r_state     <= S_PARITY;
                        end else begin
                            r_data_out <= w_rd_data;
                            r_idx      <= r_idx + 6'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_consume) begin
                        r_done     <= 1'b1;
                        r_data_out <= '0;
                        r_gap_cnt  <= '0;
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_pkt_valid <= 1'b0;
                    r_data_out  <= '0;
                end
            endcase
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign data_out  = r_data_out;
    assign cmd_err   = r_cmd_err;
    assign done      = r_done;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx.
module tb_router_pkt_tx;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_ready;
    logic       cmd_err;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       done;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    logic       corrupt_parity;
`endif

    int n_checks;
    int n_errors;

    router_pkt_tx #(.GAP_CYCLES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
        .corrupt_parity (corrupt_parity),
`endif
        .cmd_ready      (cmd_ready),
        .cmd_err        (cmd_err),
        .pl_valid       (pl_valid),
        .pl_data        (pl_data),
        .pl_ready       (pl_ready),
        .busy           (busy),
        .pkt_valid      (pkt_valid),
        .data_out       (data_out),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] a, input logic [5:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic load3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        pl_valid = 1'b1;
        pl_data  = b0; step();
        pl_data  = b1; step();
        pl_data  = b2; step();
        pl_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        pl_valid  = 1'b0;
        pl_data   = '0;
        busy      = 1'b0;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
        corrupt_parity = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state
        chk1("rst_pkt_valid", pkt_valid, 1'b0);
        chk8("rst_data_out", data_out, 8'h00);
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_pl_ready", pl_ready, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_cmd_err", cmd_err, 1'b0);

        // Basic packet: addr=1 len=3 -> header 0x0D, parity 0x0D
        issue_cmd(2'd1, 6'd3);
        chk1("b_cmd_ready_load", cmd_ready, 1'b0);
        chk1("b_pl_ready_load", pl_ready, 1'b1);
        chk1("b_pkt_valid_load", pkt_valid, 1'b0);
        load3(8'h11, 8'h22, 8'h33);
        chk8("b_hdr", data_out, 8'h0D);
        chk1("b_hdr_valid", pkt_valid, 1'b1);
        chk1("b_pl_ready_hdr", pl_ready, 1'b0);
        step(); chk8("b_p0", data_out, 8'h11); chk1("b_p0_v", pkt_valid, 1'b1);
        step(); chk8("b_p1", data_out, 8'h22); chk1("b_p1_v", pkt_valid, 1'b1);
        step(); chk8("b_p2", data_out, 8'h33); chk1("b_p2_v", pkt_valid, 1'b1);
        step(); chk8("b_par", data_out, 8'h0D); chk1("b_par_v", pkt_valid, 1'b0);
        chk1("b_done_early", done, 1'b0);
        step(); chk1("b_done", done, 1'b1); chk8("b_gap0_data", data_out, 8'h00);
        chk1("b_gap0_ready", cmd_ready, 1'b0);
        step(); chk1("b_done_width", done, 1'b0); chk1("b_gap1_ready", cmd_ready, 1'b0);
        chk1("b_gap1_valid", pkt_valid, 1'b0);
        step(); chk1("b_idle_ready", cmd_ready, 1'b1);

        // Stall: busy for 3 cycles while 0x22 is driven
        issue_cmd(2'd1, 6'd3);
        load3(8'h11, 8'h22, 8'h33);
        chk8("s_hdr", data_out, 8'h0D);
        step(); chk8("s_p0", data_out, 8'h11);
        step(); chk8("s_p1", data_out, 8'h22);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk8("s_hold_data", data_out, 8'h22);
            chk1("s_hold_valid", pkt_valid, 1'b1);
        end
        busy = 1'b0;
        step(); chk8("s_p2", data_out, 8'h33); chk1("s_p2_v", pkt_valid, 1'b1);
        step(); chk8("s_par", data_out, 8'h0D); chk1("s_par_v", pkt_valid, 1'b0);
        step(); chk1("s_done", done, 1'b1);
        step(); step();
        chk1("s_idle_ready", cmd_ready, 1'b1);

        // Illegal commands
        issue_cmd(2'd3, 6'd5);
        chk1("i1_cmd_err", cmd_err, 1'b1);
        chk1("i1_pl_ready", pl_ready, 1'b0);
        chk1("i1_cmd_ready", cmd_ready, 1'b1);
        chk1("i1_pkt_valid", pkt_valid, 1'b0);
        step(); chk1("i1_err_width", cmd_err, 1'b0); chk1("i1_pl_ready2", pl_ready, 1'b0);
        issue_cmd(2'd0, 6'd0);
        chk1("i2_cmd_err", cmd_err, 1'b1);
        chk1("i2_pl_ready", pl_ready, 1'b0);
        chk1("i2_cmd_ready", cmd_ready, 1'b1);
        chk8("i2_data_out", data_out, 8'h00);
        step(); chk1("i2_err_width", cmd_err, 1'b0); chk1("i2_pkt_valid", pkt_valid, 1'b0);

        // Maximum length: addr=2 len=63 -> header 0xFE, parity 0xC1
        issue_cmd(2'd2, 6'd63);
        pl_valid = 1'b1;
        for (int i = 0; i < 63; i++) begin
            pl_data = 8'(i);
            step();
        end
        pl_valid = 1'b0;
        chk8("m_hdr", data_out, 8'hFE);
        chk1("m_hdr_v", pkt_valid, 1'b1);
        for (int i = 0; i < 63; i++) begin
            step();
            chk8("m_payload", data_out, 8'(i));
        end
        chk1("m_last_v", pkt_valid, 1'b1);
        step(); chk8("m_par", data_out, 8'hC1); chk1("m_par_v", pkt_valid, 1'b0);
        step(); chk1("m_done", done, 1'b1);
        step(); step();
        chk1("m_idle_ready", cmd_ready, 1'b1);

        // Back-to-back: command 2 held valid through packet 1
        issue_cmd(2'd1, 6'd3);
        cmd_valid = 1'b1;
        cmd_addr  = 2'd0;
        cmd_len   = 6'd2;
        load3(8'h11, 8'h22, 8'h33);
        chk8("bb_hdr", data_out, 8'h0D);
        step(); step(); step();
        chk8("bb_p2", data_out, 8'h33);
        step(); chk8("bb_par", data_out, 8'h0D);
        step(); chk1("bb_done", done, 1'b1); chk1("bb_gap0_pl", pl_ready, 1'b0);
        step(); chk1("bb_gap1_pl", pl_ready, 1'b0);
        step(); chk1("bb_idle_ready", cmd_ready, 1'b1);
        step(); chk1("bb_accept", pl_ready, 1'b1); chk1("bb_busy_cmd", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        pl_valid  = 1'b1;
        pl_data   = 8'hA5; step();
        pl_data   = 8'h5A; step();
        pl_valid  = 1'b0;
        chk8("bb2_hdr", data_out, 8'h08);
        step(); chk8("bb2_p0", data_out, 8'hA5); chk1("bb2_p0_v", pkt_valid, 1'b1);
        reset = 1'b1;
        step();
        chk1("rm_pkt_valid", pkt_valid, 1'b0);
        chk8("rm_data_out", data_out, 8'h00);
        chk1("rm_cmd_ready", cmd_ready, 1'b1);
        chk1("rm_pl_ready", pl_ready, 1'b0);
        reset = 1'b0;
        step();
        chk1("rm_post_valid", pkt_valid, 1'b0);
        chk1("rm_post_done", done, 1'b0);

`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
        // Corrupted parity on the basic packet -> ~0x0D = 0xF2
        corrupt_parity = 1'b1;
        issue_cmd(2'd1, 6'd3);
        corrupt_parity = 1'b0;
        load3(8'h11, 8'h22, 8'h33);
        chk8("c_hdr", data_out, 8'h0D);
        step(); step(); step();
        step(); chk8("c_par", data_out, 8'hF2); chk1("c_par_v", pkt_valid, 1'b0);
        step(); chk1("c_done", done, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
